bcd_counter_display: RTL
========================

// Module: bcd_counter_display
// PURPOSE
//  N-digit decimal up/down counter driven by two push-buttons, with a time-multiplexed 7-segment display.
//  Each button is debounced, then a press-and-release produces a one-cycle count pulse.
//  The count is kept in BCD and shown one digit at a time on a shared segment bus.
//  Sits at board top level between the raw button pins and the 7-segment LED pins.
// PARAMETERS
//  NUM_DIGITS       4     number of BCD digits, counted and displayed (1..8)
//  DEBOUNCE_CYCLES  16    clk cycles a button level must be stable before it is accepted (>=2)
//  SCAN_CYCLES      1024  clk cycles each digit stays enabled before the scan advances (>=2)
// PORTS
//  clk        in   1             system clock; all state on posedge
//  reset      in   1             asynchronous, active-high
//  btn_up     in   1             raw up button, active-high, asynchronous to clk
//  btn_down   in   1             raw down button, active-high, asynchronous to clk
//  clear      in   1             synchronous clear of the count, active-high
//  ssg_d      out  7             segment bus {g,f,e,d,c,b,a}, active-low
//  ssg_en     out  NUM_DIGITS    digit enables, active-low, one-hot-low while scanning
//  count_bcd  out  4*NUM_DIGITS  current count; digit 0 (least significant) in [3:0]
//  wrap       out  1             one-cycle pulse on 99..9->0 or 0->99..9
// BEHAVIOUR
//  Reset, async: count_bcd=0, wrap=0, ssg_en=all 1s, ssg_d=7'h7F, FSMs=IDLE, scan index=0, timers=0.
//  Synchroniser: 2-flop synchroniser per button. Debounce timer restarts on any synced-level change.
//   Debounced level updates only after DEBOUNCE_CYCLES of stable input.
//  Button FSM, per button, on debounced level:
//   IDLE -(level=1)-> PRESSED.
//   PRESSED -(level=0)-> RELEASE.
//   RELEASE -> IDLE unconditionally.
//   pulse=1 only while in RELEASE.
//  Counter update, posedge only, in priority order:
//   clear=1: count=0, wrap=0; pending pulses are discarded.
//   up_pulse and down_pulse in the same cycle: no change.
//   up_pulse: BCD increment; a digit at 9 becomes 0 and carries into the next digit.
//   down_pulse: BCD decrement; a digit at 0 becomes 9 and borrows from the next digit.
//   Full wrap in either direction asserts wrap for exactly 1 cycle.
//   count_bcd changes 1 cycle after the pulse. Latency from button release to count change:
//    2 sync + DEBOUNCE_CYCLES + 2 FSM cycles.
//  Scan: prescaler counts 0..SCAN_CYCLES-1. At terminal count the digit index advances, wrapping NUM_DIGITS-1 -> 0.
//   ssg_en[idx]=0 and all other enables =1.
//   ssg_d and ssg_en are registered: 1-cycle lag after the index change, no glitch between digits.
//  Segment decode, active-low:
//   0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
//   Non-BCD nibble = 7F (blank).
//  Reset asserted mid-press: FSM returns to IDLE and no pulse is issued. After release of reset, a
//   held button needs a full release before it can count.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   Any digit k>0 whose digit and all higher digits are 0 drives ssg_d=7F while selected.
//   Digit 0 is always shown.
//  Not defined: every digit is always displayed, leading zeros included.
//  count_bcd and ssg_en are identical in both builds.
// STRUCTURE
//  Package bcd_disp_pkg:
//   btn_state_t enum {IDLE, PRESSED, RELEASE}.
//   SEG_BLANK = 7'h7F.
//   SEG_LUT[0:9] segment constants.
//   function bcd_to_seg(nibble).
//  Sub-module btn_pulse: synchroniser, debounce timer and button FSM.
//   Instantiated twice (up, down).
//   Ports: clk, reset, btn_raw -> pulse.
//   Parameter: DEBOUNCE_CYCLES.
//  Top holds the BCD counter, the scan prescaler/index and the output registers.
// TESTING
//  Reset: assert reset -> count_bcd=0, ssg_en=all 1s, ssg_d=7F, wrap=0.
//  Single press: press up for 3*DEBOUNCE, then release -> count_bcd 0000->0001 exactly once.
//   A glitch shorter than DEBOUNCE_CYCLES -> no count.
//  Carry: preload to 0099 with 99 up pulses, then 1 up -> count_bcd=0100, no wrap.
//   At 9999, 1 up -> 0000 with wrap high for 1 cycle.
//  Borrow: from 0000, 1 down -> 9999 with wrap pulse. Then 1 down -> 9998.
//  Simultaneous events: up and down pulses in the same cycle -> no change.
//   clear with a pulse in the same cycle -> 0000.
//  Scan/config: count=0042. Over 4*SCAN_CYCLES, ssg_en cycles E,D,B,7; ssg_d = 24, 19, 40, 40.
//   With LEADING_ZERO_BLANK_EN, ssg_d = 24, 19, 7F, 7F.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared types, segment constants and BCD-to-segment decode
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    RELEASE = 2'd2
  } btn_state_t;

  // Active-low segments {g,f,e,d,c,b,a}; all-ones turns every segment off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Non-BCD nibbles show as blank rather than a misleading glyph.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    if (nibble > 4'd9) return SEG_BLANK;
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/bcd_counter_display_btn_pulse.sv
// rtl/bcd_counter_display_btn_pulse.sv - button synchroniser, debouncer and press/release pulse FSM
module btn_pulse
  import bcd_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  localparam int TW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1, sync2;
  logic          level;
  logic [TW-1:0] timer;
  btn_state_t    state_q, state_d;

  // Two-flop synchroniser for the asynchronous button pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from the current one for a full window;
  // any bounce back to the current level restarts the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      timer <= '0;
    end else if (sync2 == level) begin
      timer <= '0;
    end else if (timer == TW'(DEBOUNCE_CYCLES - 1)) begin
      level <= sync2;
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // Button FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and pulse: one pulse per full press-and-release.
  always_comb begin
    state_d = state_q;
    pulse   = 1'b0;
    case (state_q)
      IDLE:    if (level)  state_d = PRESSED;
      PRESSED: if (!level) state_d = RELEASE;
      RELEASE: begin
        pulse   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/bcd_counter_display.sv
// rtl/bcd_counter_display.sv - BCD up/down counter with scanned 7-segment display; LEADING_ZERO_BLANK_EN blanks leading zeros
module bcd_counter_display
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_CYCLES     = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    clear,
  output logic [6:0]              ssg_d,
  output logic [NUM_DIGITS-1:0]   ssg_en,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;

  logic                    up_pulse, down_pulse;
  logic [4*NUM_DIGITS-1:0] count_q, inc_val, dec_val;
  logic                    inc_wrap, dec_wrap;
  logic [PS_W-1:0]         prescale;
  logic [IDX_W-1:0]        idx;
  logic [NUM_DIGITS-1:0]   blank_mask;

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
    .clk(clk), .reset(reset), .btn_raw(btn_up), .pulse(up_pulse)
  );

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
    .clk(clk), .reset(reset), .btn_raw(btn_down), .pulse(down_pulse)
  );

  // Ripple carry/borrow through the digits; a carry or borrow out of the top digit is a full wrap.
  always_comb begin
    logic carry, borrow;
    carry   = 1'b1;
    borrow  = 1'b1;
    inc_val = count_q;
    dec_val = count_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) inc_val[4*i +: 4] = 4'd0;
        else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) dec_val[4*i +: 4] = 4'd9;
        else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    inc_wrap = carry;
    dec_wrap = borrow;
  end

  // Count register: clear wins, opposing pulses cancel, wrap pulses for a single cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap    <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (up_pulse && !down_pulse) begin
        count_q <= inc_val;
        wrap    <= inc_wrap;
      end else if (down_pulse && !up_pulse) begin
        count_q <= dec_val;
        wrap    <= dec_wrap;
      end
    end
  end

  assign count_bcd = count_q;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit above digit 0 is blank when it and every higher digit are zero.
  always_comb begin
    logic hi_zero;
    hi_zero    = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      hi_zero       = hi_zero & (count_q[4*i +: 4] == 4'd0);
      blank_mask[i] = hi_zero;
    end
  end
`else
  assign blank_mask = '0;
`endif

  // Scan prescaler and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      idx      <= '0;
    end else if (prescale == PS_W'(SCAN_CYCLES - 1)) begin
      prescale <= '0;
      if (idx == IDX_W'(NUM_DIGITS - 1)) idx <= '0;
      else                               idx <= idx + IDX_W'(1);
    end else begin
      prescale <= prescale + PS_W'(1);
    end
  end

  // Registered display outputs so enables and segments switch together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ssg_en <= '1;
      ssg_d  <= SEG_BLANK;
    end else begin
      ssg_en <= ~(NUM_DIGITS'(1) << idx);
      ssg_d  <= blank_mask[idx] ? SEG_BLANK : bcd_to_seg(count_q[4*idx +: 4]);
    end
  end

endmodule
